// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage (master) and muldiv_unit (slave)
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );
    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle; MULDIV_BYPASS_EN short-cuts trivial operands
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
`ifdef MULDIV_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   m_q, m_d, spec_q, spec_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fin_q, fin_d, neg_q, neg_d, rneg_q, rneg_d, spc_q, spc_d;
    logic              accept, is_div, sa, sb, b_zero, special;
    logic [XLEN-1:0]   a_mag, b_mag, spec_val;
    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic [2*XLEN-1:0] step, sgn_prod;
    logic [XLEN-1:0]   quo, rem, final_val;
    // Request decode: operand magnitudes, result signs and the architecturally fixed special results
    always_comb begin
        accept   = state_q == IDLE && bus.in_valid && !bus.flush;
        is_div   = bus.in_op[2];
        sa       = bus.in_a[XLEN-1] && (bus.in_op == 3'd1 || bus.in_op == 3'd2 || bus.in_op == 3'd4 || bus.in_op == 3'd6);
        sb       = bus.in_b[XLEN-1] && (bus.in_op == 3'd1 || bus.in_op == 3'd4 || bus.in_op == 3'd6);
        a_mag    = sa ? -bus.in_a : bus.in_a;
        b_mag    = sb ? -bus.in_b : bus.in_b;
        b_zero   = bus.in_b == '0;
        special  = is_div ? (b_zero || (!bus.in_op[0] && bus.in_a == {1'b1, {(XLEN-1){1'b0}}} && &bus.in_b))
                          : (bus.in_a == '0 || b_zero);
        spec_val = !is_div ? '0 : b_zero ? (bus.in_op[1] ? bus.in_a : '1) : (bus.in_op[1] ? '0 : bus.in_a);
    end
    // One shift-add / restoring-divide step, plus sign correction of the finished accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, m_q};
        step      = op_q[2] ? {div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0], acc_q[XLEN-2:0], !div_diff[XLEN]}
                            : {mul_sum, acc_q[XLEN-1:1]};
        sgn_prod  = neg_q ? -acc_q : acc_q;
        quo       = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem       = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        final_val = spc_q ? spec_q : op_q[2] ? (op_q[1] ? rem : quo)
                  : op_q[1:0] == 2'd0 ? sgn_prod[XLEN-1:0] : sgn_prod[2*XLEN-1:XLEN];
    end
    // Next state: flush wins everywhere; BUSY spends one extra cycle on sign correction
    always_comb begin
        state_d = bus.flush ? IDLE
                : state_q == IDLE ? (accept ? ((BYPASS && special) ? DONE : BUSY) : IDLE)
                : state_q == BUSY ? (fin_q ? DONE : BUSY)
                : (bus.out_ready ? IDLE : DONE);
    end
    // Datapath next values: capture on acceptance, iterate in BUSY, latch the result on entry to DONE
    always_comb begin
        op_d     = op_q;
        tag_d    = tag_q;
        m_d      = m_q;
        spec_d   = spec_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        fin_d    = fin_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        spc_d    = spc_q;
        result_d = result_q;
        if (accept) begin
            op_d     = bus.in_op;
            tag_d    = bus.in_tag;
            m_d      = is_div ? b_mag : a_mag;
            acc_d    = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            cnt_d    = CW'(XLEN - 1);
            fin_d    = 1'b0;
            neg_d    = (sa ^ sb) && !(is_div && b_zero);
            rneg_d   = sa && is_div;
            spc_d    = special;
            spec_d   = spec_val;
            result_d = (BYPASS && special) ? spec_val : result_q;
        end else if (state_q == BUSY && !fin_q) begin
            acc_d = step;
            fin_d = cnt_q == '0;
            cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        end else if (state_q == BUSY && !bus.flush) begin
            result_d = final_val;
        end
    end
    // Handshake outputs are decoded straight from the state
    always_comb begin
        bus.in_ready   = state_q == IDLE;
        bus.out_valid  = state_q == DONE;
        bus.busy       = state_q != IDLE;
        bus.out_result = result_q;
        bus.out_tag    = tag_q;
    end
    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            m_q      <= '0;
            spec_q   <= '0;
            result_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            fin_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            spc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            m_q      <= m_d;
            spec_q   <= spec_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            fin_q    <= fin_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            spc_q    <= spc_d;
        end
    end
endmodule
